// File: rtl/l2_pkg.sv
// Shared definitions for the L2 tag-lookup controller:
// strobe levels, FSM encodings and address field slices.
package l2_pkg;

    localparam int L2_TAG_W = 17;
    localparam int L2_IDX_W = 9;
    localparam int L2_OFF_W = 6;

    localparam logic WRITE   = 1'b1;
    localparam logic READ    = 1'b0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COMPARE  = 3'd1,
        WB       = 3'd2,
        REFILL   = 3'd3,
        TAG_WR   = 3'd4,
        WAIT_CMP = 3'd5
    } l2_state_e;

    function automatic logic [L2_TAG_W-1:0] L2_TAG(input logic [31:0] addr);
        return addr[31 -: L2_TAG_W];
    endfunction

    function automatic logic [L2_IDX_W-1:0] L2_IDX(input logic [31:0] addr);
        return addr[L2_OFF_W +: L2_IDX_W];
    endfunction

endpackage

// File: rtl/l2_victim_sel.sv
// Miss victim choice: lowest invalid way first,
// otherwise the tree-PLRU way read from the tag RAM.
module l2_victim_sel
    import l2_pkg::*;
(
    input  logic [3:0] valid,
    input  logic [2:0] plru,
    output logic [1:0] way
);

    always_comb begin
        way = 2'd0;
        priority case (1'b1)
            !valid[0]: way = 2'd0;
            !valid[1]: way = 2'd1;
            !valid[2]: way = 2'd2;
            !valid[3]: way = 2'd3;
            default:   way = plru[0] ? (plru[2] ? 2'd3 : 2'd2)
                                     : (plru[1] ? 2'd1 : 2'd0);
        endcase
    end

endmodule

// File: rtl/l2_tag_ctrl.sv
// L2 tag-lookup controller: compare, victim pick, write-back /
// refill handshakes and tag commit toward the tag RAM.
module l2_tag_ctrl
    import l2_pkg::*;
#(
    parameter int TAG_W = L2_TAG_W,
    parameter int IDX_W = L2_IDX_W,
    parameter int OFF_W = L2_OFF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l2_req,
    input  logic [31:0]      l2_addr,
    input  logic             l2_we,
    output logic             l2_busy,
    output logic             l2_done,
    output logic             l2_hit,
    output logic [1:0]       l2_way,
    output logic [IDX_W-1:0] l2_index,
    output logic             l2_block0_rw,
    output logic             l2_block1_rw,
    output logic             l2_block2_rw,
    output logic             l2_block3_rw,
    output logic [TAG_W:0]   l2_tag_wd,
    output logic             l2_dirty_wd,
    input  logic [TAG_W:0]   l2_tag0_rd,
    input  logic [TAG_W:0]   l2_tag1_rd,
    input  logic [TAG_W:0]   l2_tag2_rd,
    input  logic [TAG_W:0]   l2_tag3_rd,
    input  logic             l2_dirty0,
    input  logic             l2_dirty1,
    input  logic             l2_dirty2,
    input  logic             l2_dirty3,
    input  logic [2:0]       plru,
    input  logic             l2_complete,
    output logic             mem_wb_req,
    output logic [31:0]      mem_wb_addr,
    input  logic             mem_wb_ack,
    output logic             mem_rd_req,
    output logic [31:0]      mem_rd_addr,
    input  logic             mem_rd_ack
);

    l2_state_e state, state_nx;

    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] vic_tag;
    logic [IDX_W-1:0] req_idx;
    logic             req_we;
    logic             hit_q;
    logic [1:0]       way_q;
    logic [TAG_W:0]   tag_wd_q;
    logic             dirty_wd_q;

    logic [TAG_W:0]   tag_rd [4];
    logic [3:0]       dirty_rd;
    logic [3:0]       valid_rd;
    logic [3:0]       hit_vec;
    logic [1:0]       hit_way;
    logic [1:0]       vic_way;
    logic             hit_any;
    logic             vic_wb;
    logic             wr_en;
    logic             unused_off;

    assign tag_rd[0] = l2_tag0_rd;
    assign tag_rd[1] = l2_tag1_rd;
    assign tag_rd[2] = l2_tag2_rd;
    assign tag_rd[3] = l2_tag3_rd;
    assign dirty_rd  = {l2_dirty3, l2_dirty2, l2_dirty1, l2_dirty0};

    always_comb begin
        valid_rd = '0;
        hit_vec  = '0;
        for (int i = 0; i < 4; i++) begin
            valid_rd[i] = tag_rd[i][TAG_W];
            hit_vec[i]  = tag_rd[i][TAG_W] &&
                          (tag_rd[i][TAG_W-1:0] == req_tag);
        end
    end

    always_comb begin
        hit_way = 2'd0;
        priority case (1'b1)
            hit_vec[0]: hit_way = 2'd0;
            hit_vec[1]: hit_way = 2'd1;
            hit_vec[2]: hit_way = 2'd2;
            hit_vec[3]: hit_way = 2'd3;
            default:    hit_way = 2'd0;
        endcase
    end

    assign hit_any = |hit_vec;

    l2_victim_sel u_victim (
        .valid (valid_rd),
        .plru  (plru),
        .way   (vic_way)
    );

    assign vic_wb = valid_rd[vic_way] & dirty_rd[vic_way];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (l2_req) state_nx = COMPARE;
            COMPARE: begin
                if (hit_any)     state_nx = TAG_WR;
                else if (vic_wb) state_nx = WB;
                else             state_nx = REFILL;
            end
            WB:       if (mem_wb_ack) state_nx = REFILL;
            REFILL:   if (mem_rd_ack) state_nx = TAG_WR;
            TAG_WR:   state_nx = WAIT_CMP;
            WAIT_CMP: if (l2_complete) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_tag    <= '0;
            req_idx    <= '0;
            req_we     <= 1'b0;
            hit_q      <= 1'b0;
            way_q      <= 2'd0;
            vic_tag    <= '0;
            tag_wd_q   <= '0;
            dirty_wd_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (l2_req) begin
                    req_tag <= L2_TAG(l2_addr);
                    req_idx <= L2_IDX(l2_addr);
                    req_we  <= l2_we;
                end
                COMPARE: begin
                    tag_wd_q <= {1'b1, req_tag};
                    hit_q    <= hit_any;
                    if (hit_any) begin
                        way_q      <= hit_way;
                        dirty_wd_q <= dirty_rd[hit_way] | req_we;
                    end else begin
                        way_q   <= vic_way;
                        vic_tag <= tag_rd[vic_way][TAG_W-1:0];
                    end
                end
                REFILL:  dirty_wd_q <= req_we;
                default: ;
            endcase
        end
    end

    assign wr_en        = (state == TAG_WR);
    assign l2_block0_rw = (wr_en && way_q == 2'd0) ? WRITE : READ;
    assign l2_block1_rw = (wr_en && way_q == 2'd1) ? WRITE : READ;
    assign l2_block2_rw = (wr_en && way_q == 2'd2) ? WRITE : READ;
    assign l2_block3_rw = (wr_en && way_q == 2'd3) ? WRITE : READ;

    assign l2_busy     = (state != IDLE);
    assign l2_done     = (state == WAIT_CMP) && l2_complete;
    assign l2_hit      = hit_q;
    assign l2_way      = way_q;
    assign l2_tag_wd   = tag_wd_q;
    assign l2_dirty_wd = dirty_wd_q;
    assign l2_index    = (state == IDLE) ? L2_IDX(l2_addr) : req_idx;

    assign mem_wb_req  = (state == WB) ? ENABLE : DISABLE;
    assign mem_rd_req  = (state == REFILL) ? ENABLE : DISABLE;
    assign mem_wb_addr = {vic_tag, req_idx, {OFF_W{1'b0}}};
    assign mem_rd_addr = {req_tag, req_idx, {OFF_W{1'b0}}};

    // line offset never reaches the tag path
    assign unused_off = ^l2_addr[OFF_W-1:0];

endmodule

// File: tb/tb_l2_tag_ctrl.sv
// Bench for l2_tag_ctrl: tag RAM and memory responders around the
// DUT, directed requests with scoreboard queues of expected results.
module tb_l2_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        l2_req;
    logic [31:0] l2_addr;
    logic        l2_we;
    logic        l2_busy, l2_done, l2_hit;
    logic [1:0]  l2_way;
    logic [8:0]  l2_index;
    logic        b0, b1, b2, b3;
    logic [17:0] l2_tag_wd;
    logic        l2_dirty_wd;
    logic [17:0] tag_q [4];
    logic [3:0]  dirty_q;
    logic [2:0]  plru_v;
    logic        cmp_q;
    logic        mem_wb_req, mem_wb_ack, mem_rd_req, mem_rd_ack;
    logic [31:0] mem_wb_addr, mem_rd_addr;

    logic [17:0] ram_tag [512][4];
    logic [3:0]  ram_dirty [512];
    logic        clr, pl_en, pl_dirty;
    logic [8:0]  pl_set;
    logic [1:0]  pl_way;
    logic [17:0] pl_tag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int mem_delay = 0;
    int wb_cnt = 0, rd_cnt = 0, wb_wait = 0, rd_wait = 0;

    logic [2:0]  exp_done [$];
    logic [20:0] exp_wr [$];
    logic [31:0] exp_wb [$];
    logic [31:0] exp_rd [$];

    always #5 clk = ~clk;

    l2_tag_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .l2_req       (l2_req),
        .l2_addr      (l2_addr),
        .l2_we        (l2_we),
        .l2_busy      (l2_busy),
        .l2_done      (l2_done),
        .l2_hit       (l2_hit),
        .l2_way       (l2_way),
        .l2_index     (l2_index),
        .l2_block0_rw (b0),
        .l2_block1_rw (b1),
        .l2_block2_rw (b2),
        .l2_block3_rw (b3),
        .l2_tag_wd    (l2_tag_wd),
        .l2_dirty_wd  (l2_dirty_wd),
        .l2_tag0_rd   (tag_q[0]),
        .l2_tag1_rd   (tag_q[1]),
        .l2_tag2_rd   (tag_q[2]),
        .l2_tag3_rd   (tag_q[3]),
        .l2_dirty0    (dirty_q[0]),
        .l2_dirty1    (dirty_q[1]),
        .l2_dirty2    (dirty_q[2]),
        .l2_dirty3    (dirty_q[3]),
        .plru         (plru_v),
        .l2_complete  (cmp_q),
        .mem_wb_req   (mem_wb_req),
        .mem_wb_addr  (mem_wb_addr),
        .mem_wb_ack   (mem_wb_ack),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_ack   (mem_rd_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // tag RAM model: registered read, write on strobe, commit ack next cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            tag_q[i]   <= ram_tag[l2_index][i];
            dirty_q[i] <= ram_dirty[l2_index][i];
        end
        cmp_q <= rst ? 1'b0 : (b0 | b1 | b2 | b3);
        if (clr) begin
            for (int s = 0; s < 512; s++) begin
                ram_dirty[s] <= 4'd0;
                for (int w = 0; w < 4; w++) ram_tag[s][w] <= 18'd0;
            end
        end else begin
            if (pl_en) begin
                ram_tag[pl_set][pl_way]   <= pl_tag;
                ram_dirty[pl_set][pl_way] <= pl_dirty;
            end
            for (int w = 0; w < 4; w++) begin
                if ({b3, b2, b1, b0}[w]) begin
                    ram_tag[l2_index][w]   <= l2_tag_wd;
                    ram_dirty[l2_index][w] <= l2_dirty_wd;
                end
            end
        end
    end

    // memory responders: ack after mem_delay waiting cycles
    always @(negedge clk) begin
        if (mem_wb_req) begin
            if (wb_wait >= mem_delay) mem_wb_ack = 1'b1;
            else begin mem_wb_ack = 1'b0; wb_wait++; end
        end else begin
            mem_wb_ack = 1'b0; wb_wait = 0;
        end
        if (mem_rd_req) begin
            if (rd_wait >= mem_delay) mem_rd_ack = 1'b1;
            else begin mem_rd_ack = 1'b0; rd_wait++; end
        end else begin
            mem_rd_ack = 1'b0; rd_wait = 0;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [2:0]  ed;
        logic [20:0] ew;
        logic [3:0]  strb;
        logic [1:0]  wobs;
        if (rst) begin
            wb_cnt = 0;
            rd_cnt = 0;
        end else begin
            if (l2_done) begin
                chk("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    ed = exp_done.pop_front();
                    chk("done_hit", l2_hit, ed[2]);
                    chk("done_way", l2_way, ed[1:0]);
                end
            end
            strb = {b3, b2, b1, b0};
            if (strb != 4'd0) begin
                strobe_cyc = cyc;
                chk("strobe_onehot", $countones(strb), 1);
                chk("strobe_expected", exp_wr.size() > 0, 1);
                wobs = strb[3] ? 2'd3 : strb[2] ? 2'd2 : strb[1] ? 2'd1 : 2'd0;
                if (exp_wr.size() > 0) begin
                    ew = exp_wr.pop_front();
                    chk("strobe_way", wobs, ew[20:19]);
                    chk("tag_wd", l2_tag_wd, ew[18:1]);
                    chk("dirty_wd", l2_dirty_wd, ew[0]);
                end
            end
            if (mem_wb_req) begin
                if (wb_cnt == 0) begin
                    chk("wb_expected", exp_wb.size() > 0, 1);
                    if (exp_wb.size() > 0)
                        chk("wb_addr", mem_wb_addr, exp_wb.pop_front());
                end
                wb_cnt++;
            end else if (wb_cnt != 0) begin
                chk("wb_hold", wb_cnt, mem_delay + 1);
                wb_cnt = 0;
            end
            if (mem_rd_req) begin
                if (rd_cnt == 0) begin
                    chk("rd_expected", exp_rd.size() > 0, 1);
                    chk("wb_before_rd", exp_wb.size(), 0);
                    if (exp_rd.size() > 0)
                        chk("rd_addr", mem_rd_addr, exp_rd.pop_front());
                end
                rd_cnt++;
            end else if (rd_cnt != 0) begin
                chk("rd_hold", rd_cnt, mem_delay + 1);
                rd_cnt = 0;
            end
        end
    end

    task automatic preload(input logic [8:0] s, input logic [1:0] w,
                           input logic [17:0] t, input logic d);
        pl_set = s; pl_way = w; pl_tag = t; pl_dirty = d; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_req(input logic [16:0] tag, input logic [8:0] idx,
                          input logic we, output int lat, output int slat);
        int n;
        int c0;
        n = 0;
        while (l2_busy && n < 200) begin @(negedge clk); n++; end
        l2_addr = {tag, idx, 6'h15};
        l2_we   = we;
        l2_req  = 1'b1;
        c0      = cyc;
        @(negedge clk);
        l2_req = 1'b0;
        l2_we  = 1'b0;
        n = 0;
        while (!l2_done && n < 200) begin @(negedge clk); n++; end
        chk("done_seen", l2_done, 1);
        lat  = cyc - c0;
        slat = strobe_cyc - c0;
        @(negedge clk);
    endtask

    initial begin
        int lat, slat, n;
        rst = 1'b1; clr = 1'b1; pl_en = 1'b0; pl_set = '0; pl_way = '0;
        pl_tag = '0; pl_dirty = 1'b0; l2_req = 1'b0; l2_addr = '0;
        l2_we = 1'b0; plru_v = 3'b000; mem_wb_ack = 1'b0; mem_rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", l2_busy, 0);
        chk("rst_done", l2_done, 0);
        chk("rst_hit", l2_hit, 0);
        chk("rst_way", l2_way, 0);
        chk("rst_strobes", {b3, b2, b1, b0}, 0);
        chk("rst_tag_wd", l2_tag_wd, 0);
        chk("rst_dirty_wd", l2_dirty_wd, 0);
        chk("rst_mem_req", {mem_wb_req, mem_rd_req}, 0);
        rst = 1'b0; clr = 1'b0;
        @(negedge clk);

        // cold miss, all invalid
        mem_delay = 0;
        exp_rd.push_back(32'h0001_2340);
        exp_wr.push_back({2'd0, 18'h20002, 1'b0});
        exp_done.push_back({1'b0, 2'd0});
        do_req(17'h2, 9'h08D, 1'b0, lat, slat);
        chk("cold_latency", lat, 4);

        // set 0: way1 invalid but tag-equal and dirty, ways 2/3 both hit
        preload(9'd0, 2'd0, {1'b1, 17'd5}, 1'b0);
        preload(9'd0, 2'd1, {1'b0, 17'd9}, 1'b1);
        preload(9'd0, 2'd2, {1'b1, 17'd9}, 1'b0);
        preload(9'd0, 2'd3, {1'b1, 17'd9}, 1'b0);
        exp_wr.push_back({2'd2, 1'b1, 17'd9, 1'b0});
        exp_done.push_back({1'b1, 2'd2});
        do_req(17'd9, 9'd0, 1'b0, lat, slat);
        chk("hit_latency", lat, 3);
        chk("hit_strobe_cyc", slat, 2);

        // write hit on clean line, then read sees it dirty
        exp_wr.push_back({2'd2, 1'b1, 17'd9, 1'b1});
        exp_done.push_back({1'b1, 2'd2});
        do_req(17'd9, 9'd0, 1'b1, lat, slat);
        exp_wr.push_back({2'd2, 1'b1, 17'd9, 1'b1});
        exp_done.push_back({1'b1, 2'd2});
        do_req(17'd9, 9'd0, 1'b0, lat, slat);

        // miss into set 0: invalid way1 beats PLRU, no write-back
        plru_v = 3'b101;
        exp_rd.push_back({17'd33, 9'd0, 6'd0});
        exp_wr.push_back({2'd1, 1'b1, 17'd33, 1'b0});
        exp_done.push_back({1'b0, 2'd1});
        do_req(17'd33, 9'd0, 1'b0, lat, slat);

        // full clean set, PLRU picks way3
        for (int w = 0; w < 4; w++)
            preload(9'd1, 2'(w), {1'b1, 17'(w + 1)}, 1'b0);
        plru_v = 3'b101;
        exp_rd.push_back({17'd100, 9'd1, 6'd0});
        exp_wr.push_back({2'd3, 1'b1, 17'd100, 1'b0});
        exp_done.push_back({1'b0, 2'd3});
        do_req(17'd100, 9'd1, 1'b0, lat, slat);

        // dirty victim way1, both acks delayed
        preload(9'd2, 2'd0, {1'b1, 17'd10}, 1'b0);
        preload(9'd2, 2'd1, {1'b1, 17'h1ABCD}, 1'b1);
        preload(9'd2, 2'd2, {1'b1, 17'd12}, 1'b0);
        preload(9'd2, 2'd3, {1'b1, 17'd13}, 1'b0);
        plru_v = 3'b010;
        mem_delay = 5;
        exp_wb.push_back({17'h1ABCD, 9'd2, 6'd0});
        exp_rd.push_back({17'h777, 9'd2, 6'd0});
        exp_wr.push_back({2'd1, 1'b1, 17'h777, 1'b1});
        exp_done.push_back({1'b0, 2'd1});
        do_req(17'h777, 9'd2, 1'b1, lat, slat);
        chk("dirty_latency", lat, 15);

        // reset in the middle of a refill
        mem_delay = 20;
        exp_rd.push_back({17'h55, 9'd3, 6'd0});
        l2_addr = {17'h55, 9'd3, 6'h00};
        l2_req  = 1'b1;
        @(negedge clk);
        l2_req = 1'b0;
        n = 0;
        while (!mem_rd_req && n < 20) begin @(negedge clk); n++; end
        chk("rd_req_before_rst", mem_rd_req, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_rd_req", mem_rd_req, 0);
        chk("rst_mid_busy", l2_busy, 0);
        chk("rst_mid_strobes", {b3, b2, b1, b0}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_delay = 0;
        chk("rst_no_commit", ram_tag[3][0], 0);
        exp_rd.push_back({17'h55, 9'd3, 6'd0});
        exp_wr.push_back({2'd0, 1'b1, 17'h55, 1'b0});
        exp_done.push_back({1'b0, 2'd0});
        do_req(17'h55, 9'd3, 1'b0, lat, slat);
        chk("post_rst_latency", lat, 4);

        repeat (3) @(negedge clk);
        chk("q_done_empty", exp_done.size(), 0);
        chk("q_wr_empty", exp_wr.size(), 0);
        chk("q_wb_empty", exp_wb.size(), 0);
        chk("q_rd_empty", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
